// File: rtl/seq_tx.sv
// seq_tx: LSB-first serial pattern transmitter with
// optional frame repeat and idle gap between frames.
module seq_tx #(
  parameter int   WIDTH    = 8,
  parameter int   RPT_W    = 4,
  parameter int   GAP_LEN  = 2,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             start,
  input  logic [RPT_W-1:0] rpt,
  input  logic             abort,
  output logic             dout,
  output logic             dvalid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST =
    GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pattern, pattern_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             dout_n, dvalid_n, fs_n;
  logic             busy_n, done_n;
  logic             emit, emit_first;
  logic [WIDTH-1:0] src;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pattern     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      rpt_cnt     <= '0;
      gap_cnt     <= '0;
      dout        <= IDLE_BIT;
      dvalid      <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      pattern     <= pattern_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      rpt_cnt     <= rpt_cnt_n;
      gap_cnt     <= gap_cnt_n;
      dout        <= dout_n;
      dvalid      <= dvalid_n;
      frame_start <= fs_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Next state; shreg rotates right so shreg[0] is the next bit
  always_comb begin
    state_n    = state;
    pattern_n  = pattern;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    rpt_cnt_n  = rpt_cnt;
    gap_cnt_n  = gap_cnt;
    dout_n     = IDLE_BIT;
    dvalid_n   = 1'b0;
    fs_n       = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    emit       = 1'b0;
    emit_first = 1'b0;
    src        = load ? pat_in : pattern;

    unique case (state)
      S_IDLE: begin
        if (load) pattern_n = pat_in;
        if (start && !abort) begin
          shreg_n   = {src[0], src[WIDTH-1:1]};
          dout_n    = src[0];
          dvalid_n  = 1'b1;
          fs_n      = 1'b1;
          busy_n    = 1'b1;
          bit_cnt_n = '0;
          rpt_cnt_n = rpt;
          state_n   = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (bit_cnt == LAST) begin
          if (rpt_cnt == '0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            rpt_cnt_n = rpt_cnt - RPT_W'(1);
            if (GAP_LEN == 0) begin
              emit       = 1'b1;
              emit_first = 1'b1;
            end else begin
              state_n   = S_GAP;
              gap_cnt_n = '0;
              busy_n    = 1'b1;
            end
          end
        end else begin
          emit = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (gap_cnt == GLAST) begin
          state_n    = S_SEND;
          emit       = 1'b1;
          emit_first = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
          busy_n    = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (emit) begin
      dout_n    = shreg[0];
      shreg_n   = {shreg[0], shreg[WIDTH-1:1]};
      dvalid_n  = 1'b1;
      busy_n    = 1'b1;
      fs_n      = emit_first;
      bit_cnt_n = emit_first ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: drives a gapped (GAP_LEN=2) and a back-to-back
// (GAP_LEN=0) seq_tx from shared inputs against a trace model.
module tb_seq_tx;

  typedef struct packed {
    logic dout;
    logic dvalid;
    logic fs;
    logic busy;
    logic done;
  } o_t;

  localparam o_t IDLE_O = o_t'(5'b10000);
  localparam o_t GAP_O  = o_t'(5'b10010);
  localparam o_t DONE_O = o_t'(5'b10001);

  logic       clk = 1'b0;
  logic       rst_n, load, start, abort;
  logic [7:0] pat_in;
  logic [3:0] rpt;

  logic dout2, dvalid2, fs2, busy2, done2;
  logic dout0, dvalid0, fs0, busy0, done0;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] mpat;
  o_t   q2[$];
  o_t   q0[$];

  seq_tx #(.WIDTH(8), .RPT_W(4), .GAP_LEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .pat_in(pat_in),
    .start(start), .rpt(rpt), .abort(abort),
    .dout(dout2), .dvalid(dvalid2), .frame_start(fs2),
    .busy(busy2), .done(done2)
  );

  seq_tx #(.WIDTH(8), .RPT_W(4), .GAP_LEN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .pat_in(pat_in),
    .start(start), .rpt(rpt), .abort(abort),
    .dout(dout0), .dvalid(dvalid0), .frame_start(fs0),
    .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input o_t got,
                     input o_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_both(input string tag, input int i);
    o_t e2, e0;
    e2 = (i < q2.size()) ? q2[i] : IDLE_O;
    e0 = (i < q0.size()) ? q0[i] : IDLE_O;
    chk({tag, "_gap2"},
        o_t'({dout2, dvalid2, fs2, busy2, done2}), e2);
    chk({tag, "_gap0"},
        o_t'({dout0, dvalid0, fs0, busy0, done0}), e0);
  endtask

  // Expected per-cycle outputs of a whole transmission
  task automatic build(input logic [7:0] p, input int r,
                       input int gap, output o_t q[$]);
    q = {};
    for (int f = 0; f <= r; f++) begin
      for (int b = 0; b < 8; b++)
        q.push_back(o_t'({p[b], 1'b1, b == 0, 1'b1, 1'b0}));
      if (f < r)
        for (int g = 0; g < gap; g++) q.push_back(GAP_O);
    end
    q.push_back(DONE_O);
  endtask

  function automatic bit both_busy(input int i);
    return i < q0.size() && q0[i].busy &&
           i < q2.size() && q2[i].busy;
  endfunction

  // Start a transmission at the current negedge and follow it
  task automatic run(input string tag, input logic [7:0] p,
                     input int r, input bit ld, input int ab);
    int n;
    load   = ld;
    pat_in = p;
    start  = 1'b1;
    abort  = 1'b0;
    rpt    = 4'(r);
    if (ld) mpat = p;
    build(mpat, r, 2, q2);
    build(mpat, r, 0, q0);
    if (ab >= 0) begin
      while (q2.size() > ab + 1) void'(q2.pop_back());
      while (q0.size() > ab + 1) void'(q0.pop_back());
    end
    n = (q2.size() > q0.size()) ? q2.size() : q0.size();
    if (ab >= 0) n = ab + 2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_both(tag, i);
      load   = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      rpt    = 4'($urandom);
      pat_in = $urandom_range(0, 1) ? 8'h00 : 8'($urandom);
      if (i == ab) begin
        abort = 1'b1;
      end else if (both_busy(i)) begin
        load  = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
    end
    load  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int r, ab;
    logic [7:0] p;
    bit ld;

    rst_n  = 1'b0;
    load   = 1'b1;
    start  = 1'b1;
    abort  = 1'b0;
    pat_in = 8'hFF;
    rpt    = 4'd0;
    q2 = {};
    q0 = {};
    mpat = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_both("reset", 0);
    end
    rst_n = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_both("post_reset", 0);
    end

    run("single_a5", 8'hA5, 0, 1'b1, -1);
    run("rpt_3c", 8'h3C, 2, 1'b1, -1);
    run("b2b_ff", 8'hFF, 1, 1'b1, -1);
    run("resend_ff", 8'h00, 0, 1'b0, -1);
    run("ld_start_81", 8'h81, 0, 1'b1, -1);

    q2 = {};
    q0 = {};
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_both("start_abort", i);
      start = 1'b0;
      abort = 1'b0;
    end

    run("abort_a5", 8'hA5, 0, 1'b1, 2);
    run("restart_a5", 8'h00, 0, 1'b0, -1);
    run("abort_gap", 8'h96, 2, 1'b1, 8);

    load   = 1'b1;
    pat_in = 8'hA5;
    start  = 1'b1;
    mpat   = 8'hA5;
    build(mpat, 0, 2, q2);
    build(mpat, 0, 0, q0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_both("pre_rst", i);
      load  = 1'b0;
      start = 1'b0;
      if (i == 4) rst_n = 1'b0;
    end
    @(negedge clk);
    q2 = {};
    q0 = {};
    chk_both("mid_rst", 0);
    rst_n = 1'b1;
    mpat  = 8'h00;
    run("cleared_pat", 8'hFF, 0, 1'b0, -1);

    for (int t = 0; t < 16; t++) begin
      p  = 8'($urandom);
      r  = $urandom_range(0, 3);
      ld = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ?
           $urandom_range(0, (r + 1) * 8 - 1) : -1;
      run("rnd", p, r, ld, ab);
    end

    @(negedge clk);
    q2 = {};
    q0 = {};
    chk_both("final_idle", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
